sdram_burst_arbiter: RTL and testbench

- Four-port burst arbiter between the dual-camera frame channels and the single sdram_core burst interface.
- Clients: two write channels (cam0, cam1 frame writers) and two read channels (display readers for the two half-screens).
- Grants one whole burst at a time using round-robin, and routes data, data-request, valid and finish strobes to the granted client only.
- Runs entirely in the 100 MHz SDRAM clock domain.

---
 rtl/sdram_burst_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_sdram_burst_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_arbiter.sv
// Four-client round-robin burst arbiter (W0, W1, R0, R1) in front of a single
// sdram_core burst port. Grants one whole burst at a time and routes strobes to the owner.
module sdram_burst_arbiter #(
   parameter int ADDR_WIDTH     = 21,
   parameter int MEM_DATA_WIDTH = 32,
   parameter int BUSRT_WIDTH    = 10
) (
   input  logic                                 i_sys_clk,
   input  logic                                 i_sys_rst,
   // client side
   input  logic [1:0]                           i_wr_burst_req,
   input  logic [1:0][BUSRT_WIDTH-1:0]          i_wr_burst_len,
   input  logic [1:0][ADDR_WIDTH-1:0]           i_wr_burst_addr,
   output logic [1:0]                           o_wr_burst_data_req,
   input  logic [1:0][MEM_DATA_WIDTH-1:0]       i_wr_burst_data,
   output logic [1:0]                           o_wr_burst_finish,
   input  logic [1:0]                           i_rd_burst_req,
   input  logic [1:0][BUSRT_WIDTH-1:0]          i_rd_burst_len,
   input  logic [1:0][ADDR_WIDTH-1:0]           i_rd_burst_addr,
   output logic [1:0]                           o_rd_burst_data_valid,
   output logic [MEM_DATA_WIDTH-1:0]            o_rd_burst_data,
   output logic [1:0]                           o_rd_burst_finish,
   // core side
   output logic                                 o_wr_burst_req,
   output logic [BUSRT_WIDTH-1:0]               o_wr_burst_len,
   output logic [ADDR_WIDTH-1:0]                o_wr_burst_addr,
   input  logic                                 i_wr_burst_data_req,
   output logic [MEM_DATA_WIDTH-1:0]            o_wr_burst_data,
   input  logic                                 i_wr_burst_finish,
   output logic                                 o_rd_burst_req,
   output logic [BUSRT_WIDTH-1:0]               o_rd_burst_len,
   output logic [ADDR_WIDTH-1:0]                o_rd_burst_addr,
   input  logic                                 i_rd_burst_data_valid,
   input  logic [MEM_DATA_WIDTH-1:0]            i_rd_burst_data,
   input  logic                                 i_rd_burst_finish,
   output logic                                 o_busy,
   output logic                                 o_len_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD,
      S_ZERO,
      S_DONE
   } state_t;

   localparam logic [BUSRT_WIDTH:0] CNT_ONE = {{BUSRT_WIDTH{1'b0}}, 1'b1};
   localparam logic [BUSRT_WIDTH:0] CNT_MAX = {(BUSRT_WIDTH+1){1'b1}};

   state_t                  state_q, state_d;
   logic [1:0]              ptr_q, ptr_d;
   logic [1:0]              gnt_q, gnt_d;
   logic [BUSRT_WIDTH-1:0]  len_q, len_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [BUSRT_WIDTH:0]    cnt_q, cnt_d;
   logic                    lenErr_q, lenErr_d;

   logic [3:0]              reqVec;
   logic [1:0]              winner;
   logic [1:0]              cand;
   logic                    found;
   logic [BUSRT_WIDTH-1:0]  winLen;
   logic [ADDR_WIDTH-1:0]   winAddr;
   logic                    beat;
   logic                    coreFin;
   logic [BUSRT_WIDTH:0]    cntNext;

   assign reqVec = {i_rd_burst_req, i_wr_burst_req};

   // First requester at or after the pointer, wrapping through all four clients.
   always_comb begin
      winner = ptr_q;
      cand   = ptr_q;
      found  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cand = ptr_q + 2'(k);
         if (!found && reqVec[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   assign winLen  = winner[1] ? i_rd_burst_len[winner[0]]  : i_wr_burst_len[winner[0]];
   assign winAddr = winner[1] ? i_rd_burst_addr[winner[0]] : i_wr_burst_addr[winner[0]];

   // Core strobes only count while a burst is actually in flight.
   assign beat    = ((state_q == S_WR) && i_wr_burst_data_req) ||
                    ((state_q == S_RD) && i_rd_burst_data_valid);
   assign coreFin = ((state_q == S_WR) && i_wr_burst_finish) ||
                    ((state_q == S_RD) && i_rd_burst_finish);
   assign cntNext = (beat && (cnt_q != CNT_MAX)) ? cnt_q + CNT_ONE : cnt_q;

   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               if (winLen == '0) begin
                  state_d = S_ZERO;
               end else if (winner[1]) begin
                  state_d = S_RD;
               end else begin
                  state_d = S_WR;
               end
            end
         end
         S_WR:    if (i_wr_burst_finish) state_d = S_DONE;
         S_RD:    if (i_rd_burst_finish) state_d = S_DONE;
         S_ZERO:  state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         ptr_q    <= 2'd0;
         gnt_q    <= 2'd0;
         len_q    <= '0;
         addr_q   <= '0;
         cnt_q    <= '0;
         lenErr_q <= 1'b0;
      end else begin
         ptr_q    <= ptr_d;
         gnt_q    <= gnt_d;
         len_q    <= len_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         lenErr_q <= lenErr_d;
      end
   end

   // The finish-cycle beat is included before comparing against the latched length.
   always_comb begin
      ptr_d    = ptr_q;
      gnt_d    = gnt_q;
      len_d    = len_q;
      addr_d   = addr_q;
      cnt_d    = cntNext;
      lenErr_d = lenErr_q;
      if ((state_q == S_IDLE) && found) begin
         ptr_d  = winner + 2'd1;
         gnt_d  = winner;
         len_d  = winLen;
         addr_d = winAddr;
         cnt_d  = '0;
      end
      if (coreFin && (cntNext != {1'b0, len_q})) begin
         lenErr_d = 1'b1;
      end
   end

   always_comb begin
      o_wr_burst_req        = 1'b0;
      o_rd_burst_req        = 1'b0;
      o_wr_burst_data       = '0;
      o_rd_burst_data       = '0;
      o_wr_burst_data_req   = 2'b00;
      o_wr_burst_finish     = 2'b00;
      o_rd_burst_data_valid = 2'b00;
      o_rd_burst_finish     = 2'b00;
      case (state_q)
         S_WR: begin
            o_wr_burst_req                 = 1'b1;
            o_wr_burst_data                = i_wr_burst_data[gnt_q[0]];
            o_wr_burst_data_req[gnt_q[0]]  = i_wr_burst_data_req;
            o_wr_burst_finish[gnt_q[0]]    = i_wr_burst_finish;
         end
         S_RD: begin
            o_rd_burst_req                   = 1'b1;
            o_rd_burst_data                  = i_rd_burst_data;
            o_rd_burst_data_valid[gnt_q[0]]  = i_rd_burst_data_valid;
            o_rd_burst_finish[gnt_q[0]]      = i_rd_burst_finish;
         end
         S_ZERO: begin
            if (gnt_q[1]) begin
               o_rd_burst_finish[gnt_q[0]] = 1'b1;
            end else begin
               o_wr_burst_finish[gnt_q[0]] = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   assign o_wr_burst_len  = len_q;
   assign o_wr_burst_addr = addr_q;
   assign o_rd_burst_len  = len_q;
   assign o_rd_burst_addr = addr_q;
   assign o_busy          = (state_q != S_IDLE);
   assign o_len_err       = lenErr_q;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Directed bench for sdram_burst_arbiter: inputs change on the falling edge and
// outputs are checked 1 ns later, well away from the rising edge.
module tb_sdram_burst_arbiter;

   localparam int AW = 21;
   localparam int DW = 32;
   localparam int BW = 10;

   logic                 sysClk = 1'b0;
   logic                 sysRst;
   logic [1:0]           wrReq;
   logic [1:0][BW-1:0]   wrLen;
   logic [1:0][AW-1:0]   wrAddr;
   logic [1:0]           wrDataReqO;
   logic [1:0][DW-1:0]   wrData;
   logic [1:0]           wrFinishO;
   logic [1:0]           rdReq;
   logic [1:0][BW-1:0]   rdLen;
   logic [1:0][AW-1:0]   rdAddr;
   logic [1:0]           rdValidO;
   logic [DW-1:0]        rdDataO;
   logic [1:0]           rdFinishO;
   logic                 coreWrReq;
   logic [BW-1:0]        coreWrLen;
   logic [AW-1:0]        coreWrAddr;
   logic                 coreWrDataReq;
   logic [DW-1:0]        coreWrData;
   logic                 coreWrFinish;
   logic                 coreRdReq;
   logic [BW-1:0]        coreRdLen;
   logic [AW-1:0]        coreRdAddr;
   logic                 coreRdValid;
   logic [DW-1:0]        coreRdData;
   logic                 coreRdFinish;
   logic                 busy;
   logic                 lenErr;

   int errors = 0;
   int checks = 0;
   logic [AW-1:0] addrTab [4];

   always #5 sysClk = ~sysClk;

   sdram_burst_arbiter #(.ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .BUSRT_WIDTH(BW)) dut (
      .i_sys_clk             (sysClk),
      .i_sys_rst             (sysRst),
      .i_wr_burst_req        (wrReq),
      .i_wr_burst_len        (wrLen),
      .i_wr_burst_addr       (wrAddr),
      .o_wr_burst_data_req   (wrDataReqO),
      .i_wr_burst_data       (wrData),
      .o_wr_burst_finish     (wrFinishO),
      .i_rd_burst_req        (rdReq),
      .i_rd_burst_len        (rdLen),
      .i_rd_burst_addr       (rdAddr),
      .o_rd_burst_data_valid (rdValidO),
      .o_rd_burst_data       (rdDataO),
      .o_rd_burst_finish     (rdFinishO),
      .o_wr_burst_req        (coreWrReq),
      .o_wr_burst_len        (coreWrLen),
      .o_wr_burst_addr       (coreWrAddr),
      .i_wr_burst_data_req   (coreWrDataReq),
      .o_wr_burst_data       (coreWrData),
      .i_wr_burst_finish     (coreWrFinish),
      .o_rd_burst_req        (coreRdReq),
      .o_rd_burst_len        (coreRdLen),
      .o_rd_burst_addr       (coreRdAddr),
      .i_rd_burst_data_valid (coreRdValid),
      .i_rd_burst_data       (coreRdData),
      .i_rd_burst_finish     (coreRdFinish),
      .o_busy                (busy),
      .o_len_err             (lenErr)
   );

   task automatic applyStimulus();
      @(negedge sysClk);
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clearCore();
      coreWrDataReq = 1'b0;
      coreWrFinish  = 1'b0;
      coreRdValid   = 1'b0;
      coreRdFinish  = 1'b0;
      coreRdData    = '0;
      wrData        = '0;
   endtask

   // Runs one granted burst, starting on the IDLE cycle where the client's
   // request is already present and ending on the following IDLE cycle.
   // dropMode: 0 keep requests, 1 drop granted client, 2 drop every client.
   task automatic doBurst(input int c, input int len, input int beats,
                          input logic [31:0] seed, input int dropMode);
      logic [1:0]  oh;
      logic [31:0] val;
      oh = (c % 2 == 1) ? 2'b10 : 2'b01;
      #1 checkOutput("idle_busy", busy, 0);
      applyStimulus();
      if (c < 2) begin
         #1;
         checkOutput("core_wr_req", coreWrReq, 1);
         checkOutput("core_rd_quiet", coreRdReq, 0);
         checkOutput("core_wr_len", coreWrLen, len);
         checkOutput("core_wr_addr", coreWrAddr, addrTab[c]);
      end else begin
         #1;
         checkOutput("core_rd_req", coreRdReq, 1);
         checkOutput("core_wr_quiet", coreWrReq, 0);
         checkOutput("core_rd_len", coreRdLen, len);
         checkOutput("core_rd_addr", coreRdAddr, addrTab[c]);
      end
      for (int b = 0; b < beats; b++) begin
         val = seed + 32'(b);
         if (c < 2) begin
            coreWrDataReq     = 1'b1;
            coreWrFinish      = (b == beats - 1);
            wrData[c % 2]     = val;
            wrData[1 - c % 2] = ~val;
            #1;
            checkOutput("wr_route", wrDataReqO, oh);
            checkOutput("wr_data", coreWrData, val);
            checkOutput("wr_fin_route", wrFinishO, (b == beats - 1) ? oh : 2'b00);
         end else begin
            coreRdValid  = 1'b1;
            coreRdFinish = (b == beats - 1);
            coreRdData   = val;
            #1;
            checkOutput("rd_route", rdValidO, oh);
            checkOutput("rd_data", rdDataO, val);
            checkOutput("rd_fin_route", rdFinishO, (b == beats - 1) ? oh : 2'b00);
         end
         applyStimulus();
      end
      // DONE cycle: stray core strobes must not reach anyone
      clearCore();
      coreWrDataReq = 1'b1;
      coreRdValid   = 1'b1;
      coreWrFinish  = 1'b1;
      if (dropMode == 1) begin
         if (c < 2) wrReq[c % 2] = 1'b0;
         else rdReq[c % 2] = 1'b0;
      end else if (dropMode == 2) begin
         wrReq = 2'b00;
         rdReq = 2'b00;
      end
      #1;
      checkOutput("done_busy", busy, 1);
      checkOutput("done_core_req", {coreWrReq, coreRdReq}, 2'b00);
      checkOutput("done_stray", {wrDataReqO, rdValidO, wrFinishO}, 6'b0);
      applyStimulus();
      clearCore();
      #1;
      checkOutput("post_idle_busy", busy, 0);
      checkOutput("post_core_req", {coreWrReq, coreRdReq}, 2'b00);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      addrTab[0] = 21'h00100;
      addrTab[1] = 21'h04200;
      addrTab[2] = 21'h10300;
      addrTab[3] = 21'h18400;
      sysRst = 1'b1;
      wrReq = 2'b00; rdReq = 2'b00;
      wrLen = '0; rdLen = '0; wrAddr = '0; rdAddr = '0;
      clearCore();
      applyStimulus();
      applyStimulus();
      #1;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_core_req", {coreWrReq, coreRdReq}, 2'b00);
      checkOutput("rst_len_err", lenErr, 0);
      checkOutput("rst_core_len", coreWrLen, 0);
      checkOutput("rst_strobes", {wrDataReqO, wrFinishO, rdValidO, rdFinishO}, 8'b0);
      applyStimulus();
      sysRst = 1'b0;

      // Single W0 write, len 8
      applyStimulus();
      wrLen[0] = 10'd8; wrAddr[0] = addrTab[0]; wrReq[0] = 1'b1;
      doBurst(0, 8, 8, 32'h1234_0000, 2);
      checkOutput("t1_len_err", lenErr, 0);

      // Reset pulse brings the pointer back to W0
      sysRst = 1'b1;
      applyStimulus();
      sysRst = 1'b0;

      // All four requesting, len 4: expected order W0, W1, R0, R1, W0
      wrLen = {10'd4, 10'd4}; rdLen = {10'd4, 10'd4};
      wrAddr[0] = addrTab[0]; wrAddr[1] = addrTab[1];
      rdAddr[0] = addrTab[2]; rdAddr[1] = addrTab[3];
      wrReq = 2'b11; rdReq = 2'b11;
      doBurst(0, 4, 4, 32'hA000_0000, 0);
      doBurst(1, 4, 4, 32'hA000_0010, 0);
      doBurst(2, 4, 4, 32'hA000_0020, 0);
      doBurst(3, 4, 4, 32'hA000_0030, 0);
      doBurst(0, 4, 4, 32'hA000_0040, 2);
      checkOutput("t2_len_err", lenErr, 0);

      // R1 read, len 16
      applyStimulus();
      rdLen[1] = 10'd16; rdAddr[1] = addrTab[3]; rdReq[1] = 1'b1;
      doBurst(3, 16, 16, 32'h5500_0000, 2);

      // W1 zero length: never reaches the core
      applyStimulus();
      wrLen[1] = 10'd0; wrAddr[1] = addrTab[1]; wrReq[1] = 1'b1;
      #1 checkOutput("z_idle_busy", busy, 0);
      applyStimulus();
      #1;
      checkOutput("z_finish", wrFinishO, 2'b10);
      checkOutput("z_no_core_req", {coreWrReq, coreRdReq}, 2'b00);
      checkOutput("z_busy", busy, 1);
      wrReq[1] = 1'b0;
      applyStimulus();
      #1;
      checkOutput("z_done_finish", wrFinishO, 2'b00);
      checkOutput("z_done_core_req", {coreWrReq, coreRdReq}, 2'b00);
      checkOutput("z_done_busy", busy, 1);
      applyStimulus();
      #1 checkOutput("z_back_idle", busy, 0);

      // R0 len 10 but only 9 valids: sticky length error
      applyStimulus();
      rdLen[0] = 10'd10; rdAddr[0] = addrTab[2]; rdReq[0] = 1'b1;
      doBurst(2, 10, 9, 32'hBEEF_0000, 2);
      checkOutput("le_set", lenErr, 1);
      applyStimulus();
      wrLen[0] = 10'd2; wrAddr[0] = addrTab[0]; wrReq[0] = 1'b1;
      doBurst(0, 2, 2, 32'h0000_7700, 2);
      checkOutput("le_sticky", lenErr, 1);

      // Reset in the middle of a W0 write at beat 3
      applyStimulus();
      wrLen[0] = 10'd8; wrAddr[0] = addrTab[0]; wrReq[0] = 1'b1;
      applyStimulus();
      #1 checkOutput("mr_core_req", coreWrReq, 1);
      for (int b = 0; b < 3; b++) begin
         coreWrDataReq = 1'b1;
         wrData[0] = 32'hC0DE_0000 + 32'(b);
         applyStimulus();
      end
      coreWrDataReq = 1'b1;
      wrData[0] = 32'hC0DE_0003;
      sysRst = 1'b1;
      #1;
      checkOutput("mr_busy", busy, 0);
      checkOutput("mr_core_req0", {coreWrReq, coreRdReq}, 2'b00);
      checkOutput("mr_route", wrDataReqO, 2'b00);
      checkOutput("mr_wdata", coreWrData, 0);
      checkOutput("mr_len_err", lenErr, 0);
      checkOutput("mr_core_len", coreWrLen, 0);
      applyStimulus();
      sysRst = 1'b0;
      clearCore();
      wrLen[0] = 10'd3;
      rdLen[1] = 10'd5; rdAddr[1] = addrTab[3]; rdReq[1] = 1'b1;
      doBurst(0, 3, 3, 32'h0F0F_0000, 1);
      doBurst(3, 5, 5, 32'hF0F0_0000, 2);
      checkOutput("mr_len_ok", lenErr, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
